// File: rtl/enum_track_flat_if.sv
// rtl/enum_track_flat_if.sv - flattened sample/result bus for enum_track_flat
interface enum_track_flat_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic [W:0]         in_flat;
  logic [W+CNT_W+2:0] out_flat;

  modport master (output in_flat, input out_flat);
  modport slave  (input in_flat, output out_flat);
endinterface

// File: rtl/enum_track_flat.sv
// rtl/enum_track_flat.sv - registered enum sanitiser, target counter and run detector
module enum_track_flat #(
  parameter int W         = 4,
  parameter int NUM_LEGAL = 6,
  parameter int TARGET    = 2,
  parameter int DEFAULT   = 0,
  parameter int RUN_LEN   = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  enum_track_flat_if.slave bus
);
  localparam int RC_W = $clog2(RUN_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, LOCK} state_t;

  state_t           state, state_n;
  logic [RC_W-1:0]  run_cnt, run_cnt_n;
  logic [W-1:0]     e_out_q;
  logic [CNT_W-1:0] hit_cnt;
  logic             is_target_q, illegal_q, run_hit;

  logic         in_valid;
  logic [W-1:0] e_in;
  logic         legal, is_tgt;

  assign in_valid = bus.in_flat[W];
  assign e_in     = bus.in_flat[W-1:0];

  // Extend by one bit so NUM_LEGAL == 2**W is representable.
  assign legal  = ({1'b0, e_in} < (W+1)'(NUM_LEGAL));
  assign is_tgt = (e_in == W'(TARGET));

  always_ff @(posedge clk) begin
    if (rst) begin
      e_out_q     <= W'(DEFAULT);
      hit_cnt     <= '0;
      is_target_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      is_target_q <= in_valid && is_tgt;
      illegal_q   <= in_valid && !legal;
      if (in_valid) begin
        e_out_q <= legal ? e_in : W'(DEFAULT);
        if (is_tgt && (hit_cnt != {CNT_W{1'b1}}))
          hit_cnt <= hit_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      run_cnt <= '0;
    end else begin
      state   <= state_n;
      run_cnt <= run_cnt_n;
    end
  end

  // Idle cycles leave state and run_cnt untouched, so gaps do not break a run.
  always_comb begin
    state_n   = state;
    run_cnt_n = run_cnt;
    if (in_valid) begin
      if (is_tgt) begin
        case (state)
          IDLE: begin
            run_cnt_n = RC_W'(1);
            state_n   = (RUN_LEN == 1) ? LOCK : RUN;
          end
          RUN: begin
            run_cnt_n = run_cnt + RC_W'(1);
            if (run_cnt + RC_W'(1) == RC_W'(RUN_LEN))
              state_n = LOCK;
          end
          LOCK: begin
            run_cnt_n = RC_W'(RUN_LEN);
          end
          default: begin
            state_n   = IDLE;
            run_cnt_n = '0;
          end
        endcase
      end else begin
        state_n   = IDLE;
        run_cnt_n = '0;
      end
    end
  end

  assign run_hit = (state == LOCK);

  assign bus.out_flat = {e_out_q, hit_cnt, is_target_q, illegal_q, run_hit};
endmodule

// File: tb/tb_enum_track_flat.sv
// tb/tb_enum_track_flat.sv - scoreboard bench for enum_track_flat (CNT_W=8 and CNT_W=3 instances)
module tb_enum_track_flat;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  enum_track_flat_if #(.W(4), .CNT_W(8)) if_a ();
  enum_track_flat_if #(.W(4), .CNT_W(3)) if_b ();

  enum_track_flat #(.W(4), .NUM_LEGAL(6), .TARGET(2), .DEFAULT(0), .RUN_LEN(3), .CNT_W(8))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  enum_track_flat #(.W(4), .NUM_LEGAL(6), .TARGET(2), .DEFAULT(0), .RUN_LEN(3), .CNT_W(3))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  int checks   = 0;
  int failures = 0;

  logic [14:0] q_a[$];
  logic [9:0]  q_b[$];

  // Reference model: consecutive-target streak, independent of any FSM encoding.
  logic [3:0] m_e;
  int         m_cnt, m_streak;
  logic       m_tgt, m_ill;

  task automatic model(input logic r, input logic v, input logic [3:0] e);
    if (r) begin
      m_e = 4'd0; m_cnt = 0; m_streak = 0; m_tgt = 0; m_ill = 0;
    end else if (v) begin
      m_e   = (e < 6) ? e : 4'd0;
      m_tgt = (e == 4'd2);
      m_ill = (e >= 6);
      if (e == 4'd2) begin
        m_cnt++;
        m_streak++;
      end else begin
        m_streak = 0;
      end
    end else begin
      m_tgt = 0; m_ill = 0;
    end
  endtask

  task automatic check15(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check10(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] e);
    logic run;
    @(negedge clk);
    rst = r;
    if_a.in_flat = {v, e};
    if_b.in_flat = {v, e};
    model(r, v, e);
    run = (m_streak >= 3);
    q_a.push_back({m_e, 8'(m_cnt), m_tgt, m_ill, run});
    q_b.push_back({m_e, 3'((m_cnt > 7) ? 7 : m_cnt), m_tgt, m_ill, run});
    @(posedge clk);
    #1;
    check15("out_a", if_a.out_flat, q_a.pop_front());
    check10("out_b", if_b.out_flat, q_b.pop_front());
  endtask

  initial begin
    if_a.in_flat = '0;
    if_b.in_flat = '0;
    model(1'b1, 1'b0, 4'd0);

    // 1: reset then idle
    step(1, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    check15("idle_zero", if_a.out_flat, 15'h0000);

    // 2: legal/illegal sweep
    for (int i = 0; i < 16; i++) step(0, 1, 4'(i));
    check15("sweep_cnt", 15'(if_a.out_flat[10:3]), 15'd1);

    // 3: run lock with a gap, then break
    step(1, 0, 0);
    step(0, 1, 2); step(0, 1, 2);
    check15("gap_run0", 15'(if_a.out_flat[0]), 15'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(0, 1, 2);
    check15("gap_run1", 15'(if_a.out_flat[0]), 15'd1);
    step(0, 1, 3);
    check15("gap_break", 15'(if_a.out_flat[0]), 15'd0);
    check15("gap_cnt", 15'(if_a.out_flat[10:3]), 15'd3);

    // 4: run broken by illegal code
    step(1, 0, 0);
    step(0, 1, 2); step(0, 1, 2); step(0, 1, 9);
    check15("ill_pulse", 15'(if_a.out_flat[1]), 15'd1);
    step(0, 1, 2); step(0, 1, 2);
    check15("ill_run0", 15'(if_a.out_flat[0]), 15'd0);
    step(0, 1, 2);
    check15("ill_run1", 15'(if_a.out_flat[0]), 15'd1);
    check15("ill_cnt", 15'(if_a.out_flat[10:3]), 15'd5);

    // 5: saturation on the 3-bit counter
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 2);
    check10("sat_cnt", 10'(if_b.out_flat[5:3]), 10'd7);
    check10("sat_run", 10'(if_b.out_flat[0]), 10'd1);
    check15("nosat_cnt", 15'(if_a.out_flat[10:3]), 15'd10);

    // 6: reset dominates a valid target sample while locked
    step(0, 1, 2);
    step(1, 1, 2);
    check15("rst_dom", if_a.out_flat, 15'h0000);
    step(0, 1, 2);
    check15("post_rst", if_a.out_flat, {4'd2, 8'd1, 3'b100});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/enum_track_flat.md
Name: enum_track_flat

Overview:
Parametrised, registered successor to the flattened enum decoder.
- Samples a W-bit enum code from a flattened input bus under a valid qualifier.
- Sanitises codes outside the legal set to a default value.
- Flags the target enumerator and keeps a saturating target-hit count.
- Runs a small FSM that detects RUN_LEN consecutive target samples.
- All results are packed into one flattened output bus for coverage and fuzz harnesses.

Parameters:
W, 4, enum code width in bits
NUM_LEGAL, 6, legal codes are 0..NUM_LEGAL-1; requires NUM_LEGAL <= 2**W
TARGET, 2, enumerator that is flagged and counted; requires TARGET < NUM_LEGAL
DEFAULT, 0, value substituted for illegal codes; requires DEFAULT < NUM_LEGAL
RUN_LEN, 3, consecutive target samples needed to lock; requires RUN_LEN >= 1
CNT_W, 8, width of the hit counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_flat  input  W+1  [W]=in_valid, [W-1:0]=e_in
out_flat  output  W+CNT_W+3  fields, MSB to LSB: [W+CNT_W+2:CNT_W+3]=e_out_q, [CNT_W+2:3]=hit_cnt, [2]=is_target_q, [1]=illegal_q, [0]=run_hit

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and dominates in_valid in the same cycle.
- Reset values:
  - e_out_q=DEFAULT; hit_cnt=0; is_target_q=0; illegal_q=0; run_hit=0.
  - FSM=IDLE; internal run_cnt=0.
- Sample:
  - A sample is taken on any rising edge with in_valid=1 and rst=0.
  - All outputs are registered. Latency is 1 cycle from the sampling edge.
  - No combinational path from in_flat to out_flat.
- legal = (e_in < NUM_LEGAL), compared unsigned.
  - When NUM_LEGAL = 2**W, every code is legal and illegal_q is never asserted.
- e_out_q:
  - On a sample: e_in if legal, else DEFAULT.
  - Holds its value on cycles with in_valid=0.
- is_target_q: 1 for exactly the cycle after a sample with e_in==TARGET; otherwise 0.
- illegal_q: 1 for exactly the cycle after a sample with an illegal code; otherwise 0.
- is_target_q and illegal_q are never both 1.
- hit_cnt:
  - +1 on each target sample.
  - Saturates at 2**CNT_W-1; no wrap.
  - Cleared only by rst.
- FSM states: IDLE, RUN, LOCK. Transitions are evaluated only on sample edges; in_valid=0 holds the state and run_cnt, so gaps do not break a run.
  - IDLE:
    - target sample -> run_cnt=1; go to LOCK if RUN_LEN==1, else RUN.
    - any other sample -> stay in IDLE.
  - RUN:
    - target sample -> run_cnt+1; go to LOCK when run_cnt+1 == RUN_LEN, else stay in RUN.
    - legal non-target sample or illegal sample -> go to IDLE, run_cnt=0.
  - LOCK:
    - target sample -> stay in LOCK; run_cnt holds at RUN_LEN.
    - legal non-target sample or illegal sample -> go to IDLE, run_cnt=0.
  - run_hit = (state==LOCK). It rises in the same cycle that is_target_q reports the RUN_LEN-th consecutive target, and it falls in the same cycle that the breaking sample's result appears.
- run_cnt width is clog2(RUN_LEN+1).
- Reset mid-run clears run_cnt and FSM state. hit_cnt is lost.

Test Plan:
1. Reset then idle (rst=1 for 2 cycles, then in_valid=0 for 5 cycles) -> out_flat = {4'd0, 8'd0, 3'b000} = 15'h0000 throughout.
2. Legal/illegal sweep (valid samples e_in = 0..15) -> one cycle later each: e_out_q = e_in for 0..5 and 0 for 6..15; illegal_q=1 only for 6..15; is_target_q=1 only for e_in=2; final hit_cnt=1.
3. Run lock with a gap (samples 2,2 / in_valid=0 for 3 cycles / sample 2, then sample 3):
   - run_hit=0 after the first two samples.
   - run_hit=1 in the cycle after the third target sample.
   - run_hit=0 the cycle after the sample of 3.
   - hit_cnt=3.
4. Run broken by illegal code (samples 2,2,9,2,2,2) -> run_hit stays 0 until the 6th sample result, then 1; illegal_q pulses once; hit_cnt=5.
5. Saturation (CNT_W=3, 10 consecutive target samples) -> hit_cnt reaches 7 and holds at 7; run_hit stays 1 from the 3rd result onward.
6. Reset dominance (rst=1 together with a valid target sample while in LOCK) -> next cycle all fields are at reset values; a following single target sample gives run_hit=0 and hit_cnt=1.
